mult_arbiter: RTL and testbench
===============================

MULT_ARBITER -- requirements
Module: mult_arbiter

Interface
REQ-001 The module SHALL have parameter NUM_REQ, default 4, giving the number of requesters (range 2..8).
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The module SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The module SHALL have port req_valid, input, NUM_REQ bits: per-requester operation request.
REQ-005 The module SHALL have port req_ready, output, NUM_REQ bits: per-requester accept; a request is taken when req_valid[i] and req_ready[i] are both high.
REQ-006 The module SHALL have port req_a, input, 4*NUM_REQ bits: operand a, requester i at bits [4i+3:4i].
REQ-007 The module SHALL have port req_b, input, 4*NUM_REQ bits: operand b, same packing.
REQ-008 The module SHALL have port resp_valid, output, NUM_REQ bits: result valid for the owning requester.
REQ-009 The module SHALL have port resp_ready, input, NUM_REQ bits: per-requester result accept.
REQ-010 The module SHALL have port resp_data, output, 8 bits: product a*b.
REQ-011 The module SHALL have port resp_id, output, $clog2(NUM_REQ) bits: index of the owning requester.
REQ-012 The module SHALL have ports mul_in_a and mul_in_b, outputs, 4 bits each: operands to the shared repeated-addition multiplier.
REQ-013 The module SHALL have port mul_valid_in, output, 1 bit: issue strobe to the multiplier.
REQ-014 The module SHALL have port mul_ready_out, input, 1 bit: multiplier idle/accept.
REQ-015 The module SHALL have port mul_out, input, 8 bits: multiplier product.
REQ-016 The module SHALL have port mul_valid_out, input, 1 bit: multiplier done, level-held until the next issue.
REQ-017 The module SHALL have port busy, output, 1 bit: high whenever the FSM is not IDLE.

Function
REQ-018 The FSM SHALL have states IDLE, ISSUE, WAIT and RESP.
REQ-019 In IDLE, the module SHALL grant one requester with req_valid high, assert req_ready only for it (combinationally), and latch a, b and id on that edge.
REQ-020 Default arbitration SHALL be round-robin: search starts at rr_ptr; after a grant to requester k, rr_ptr SHALL become (k+1) mod NUM_REQ.
REQ-021 req_ready SHALL be all-zero in every state other than IDLE.
REQ-022 From IDLE with a grant, the FSM SHALL go to RESP with product 0 if the latched a==0 or b==0 (zero bypass; the multiplier never completes b==0), and to ISSUE otherwise.
REQ-023 In ISSUE, mul_valid_in SHALL be 1 with the latched operands on mul_in_a/mul_in_b; on mul_ready_out==1, the FSM SHALL go to WAIT.
REQ-024 In WAIT, on mul_valid_out==1, the module SHALL capture mul_out into the result register and go to RESP; mul_valid_out SHALL be ignored in all other states.
REQ-025 In RESP, resp_valid[id] SHALL be 1, with resp_data and resp_id held stable; on resp_ready[id]==1, the FSM SHALL go to IDLE; resp_ready of other bits SHALL be ignored.
REQ-026 Latency from accept to resp_valid SHALL be 1 cycle for a zero operand; otherwise 1 cycle plus the ISSUE wait, plus b multiplier cycles, plus 1.
REQ-027 A requester dropping req_valid before it is granted SHALL NOT be granted; operands are sampled only at the accept edge.
REQ-028 Only one operation SHALL be outstanding at a time; no new grant while busy.

Reset
REQ-029 Reset SHALL force the FSM to IDLE, rr_ptr=0, and result, latched operands and id to 0.
REQ-030 In reset, resp_valid, mul_valid_in and busy SHALL be 0, and req_ready SHALL be 0.
REQ-031 Reset mid-operation SHALL abandon the in-flight operation with no response; the multiplier is reset by the same rst_n.

Configuration
REQ-032 With macro MULT_ARB_FIXED_PRIORITY_EN defined, arbitration SHALL be fixed priority (lowest index wins) and rr_ptr SHALL be removed; when undefined, round-robin per REQ-020 SHALL apply.

Verification
REQ-033 The bench SHALL cover: req 0 only, a=3, b=5 -> resp_valid[0], resp_data=0x0F, resp_id=0, one mul_valid_in issue.
REQ-034 The bench SHALL cover: all 4 requesters valid continuously, a=i+1, b=2 -> grants 0,1,2,3,0 in order (round-robin) and each data=2*(i+1).
REQ-035 The bench SHALL cover: req 2, a=7, b=0 -> resp_data=0 one cycle after accept, mul_valid_in never asserted.
REQ-036 The bench SHALL cover: a=15, b=15 with resp_ready held low 5 cycles -> resp_data=0xE1 held stable, no new req_ready until accepted.
REQ-037 The bench SHALL cover: rst_n low during WAIT -> FSM in IDLE, all outputs 0, then a fresh request a=2, b=3 -> 6.
REQ-038 The bench SHALL cover: with MULT_ARB_FIXED_PRIORITY_EN, requesters 1 and 3 continuously valid -> requester 1 always granted.

Source files
------------

// File: rtl/mult_arbiter.sv
// Arbitrates NUM_REQ requesters onto one shared 4x4 repeated-addition multiplier.
// Define MULT_ARB_FIXED_PRIORITY_EN for lowest-index-wins arbitration; round-robin otherwise.
module mult_arbiter #(
   parameter int NUM_REQ = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [NUM_REQ-1:0]         req_valid,
   output logic [NUM_REQ-1:0]         req_ready,
   input  logic [4*NUM_REQ-1:0]       req_a,
   input  logic [4*NUM_REQ-1:0]       req_b,
   output logic [NUM_REQ-1:0]         resp_valid,
   input  logic [NUM_REQ-1:0]         resp_ready,
   output logic [7:0]                 resp_data,
   output logic [$clog2(NUM_REQ)-1:0] resp_id,
   output logic [3:0]                 mul_in_a,
   output logic [3:0]                 mul_in_b,
   output logic                       mul_valid_in,
   input  logic                       mul_ready_out,
   input  logic [7:0]                 mul_out,
   input  logic                       mul_valid_out,
   output logic                       busy
);

   localparam int IdW = $clog2(NUM_REQ);

   localparam logic [1:0] StIdle  = 2'd0;
   localparam logic [1:0] StIssue = 2'd1;
   localparam logic [1:0] StWait  = 2'd2;
   localparam logic [1:0] StResp  = 2'd3;

   logic [1:0]     state_q, state_d;
   logic [3:0]     a_q, a_d;
   logic [3:0]     b_q, b_d;
   logic [IdW-1:0] id_q, id_d;
   logic [7:0]     result_q, result_d;

   logic           grant_found;
   logic [IdW-1:0] grant_idx;
   logic [3:0]     sel_a, sel_b;

`ifdef MULT_ARB_FIXED_PRIORITY_EN
   // Descending scan so the lowest valid index is the last (winning) assignment.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (req_valid[IdW'(i)]) begin
            grant_found = 1'b1;
            grant_idx   = IdW'(i);
         end
      end
   end
`else
   logic [IdW-1:0] rr_ptr_q, rr_ptr_d;

   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         int cand;
         cand = (int'(rr_ptr_q) + i) % NUM_REQ;
         if (!grant_found && req_valid[IdW'(cand)]) begin
            grant_found = 1'b1;
            grant_idx   = IdW'(cand);
         end
      end
   end

   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (state_q == StIdle && grant_found) begin
         rr_ptr_d = (grant_idx == IdW'(NUM_REQ - 1)) ? '0 : grant_idx + IdW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr_q <= '0;
      end else begin
         rr_ptr_q <= rr_ptr_d;
      end
   end
`endif

   always_comb begin
      sel_a = '0;
      sel_b = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant_idx == IdW'(i)) begin
            sel_a = req_a[4*i +: 4];
            sel_b = req_b[4*i +: 4];
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      id_d     = id_q;
      result_d = result_q;
      case (state_q)
         StIdle: begin
            if (grant_found) begin
               a_d  = sel_a;
               b_d  = sel_b;
               id_d = grant_idx;
               // The multiplier never finishes b==0, so zero operands skip it entirely.
               if (sel_a == 4'd0 || sel_b == 4'd0) begin
                  result_d = '0;
                  state_d  = StResp;
               end else begin
                  state_d = StIssue;
               end
            end
         end
         StIssue: begin
            if (mul_ready_out) state_d = StWait;
         end
         StWait: begin
            if (mul_valid_out) begin
               result_d = mul_out;
               state_d  = StResp;
            end
         end
         StResp: begin
            if (resp_ready[id_q]) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         a_q      <= '0;
         b_q      <= '0;
         id_q     <= '0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         id_q     <= id_d;
         result_q <= result_d;
      end
   end

   // Gated by rst_n so no requester sees an accept while reset is held.
   always_comb begin
      req_ready = '0;
      if (rst_n && state_q == StIdle && grant_found) req_ready[grant_idx] = 1'b1;
   end

   always_comb begin
      resp_valid = '0;
      if (state_q == StResp) resp_valid[id_q] = 1'b1;
   end

   assign resp_data    = result_q;
   assign resp_id      = id_q;
   assign mul_in_a     = a_q;
   assign mul_in_b     = b_q;
   assign mul_valid_in = (state_q == StIssue);
   assign busy         = (state_q != StIdle);

endmodule

// File: tb/tb_mult_arbiter.sv
// Self-checking bench for mult_arbiter with a behavioural repeated-addition multiplier.
// Expectations follow MULT_ARB_FIXED_PRIORITY_EN when that macro is defined.
module tb_mult_arbiter;

   logic        clk;
   logic        rst_n;
   logic [3:0]  req_valid, req_ready, resp_valid, resp_ready;
   logic [15:0] req_a, req_b;
   logic [7:0]  resp_data;
   logic [1:0]  resp_id;
   logic [3:0]  mul_in_a, mul_in_b;
   logic        mul_valid_in, mul_ready_out, mul_valid_out;
   logic [7:0]  mul_out;
   logic        busy;

   mult_arbiter #(.NUM_REQ(4)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_a        (req_a),
      .req_b        (req_b),
      .resp_valid   (resp_valid),
      .resp_ready   (resp_ready),
      .resp_data    (resp_data),
      .resp_id      (resp_id),
      .mul_in_a     (mul_in_a),
      .mul_in_b     (mul_in_b),
      .mul_valid_in (mul_valid_in),
      .mul_ready_out(mul_ready_out),
      .mul_out      (mul_out),
      .mul_valid_out(mul_valid_out),
      .busy         (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Multiplier model: b accumulate cycles after the issue edge, result level-held.
   logic       m_busy;
   logic [3:0] m_cnt, m_a;
   logic [7:0] m_acc;
   assign mul_ready_out = !m_busy;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_busy        <= 1'b0;
         m_cnt         <= '0;
         m_a           <= '0;
         m_acc         <= '0;
         mul_valid_out <= 1'b0;
         mul_out       <= '0;
      end else if (mul_valid_in && !m_busy) begin
         m_busy        <= 1'b1;
         m_a           <= mul_in_a;
         m_cnt         <= mul_in_b;
         m_acc         <= '0;
         mul_valid_out <= 1'b0;
      end else if (m_busy) begin
         if (m_cnt == 4'd1) begin
            m_busy        <= 1'b0;
            mul_valid_out <= 1'b1;
            mul_out       <= m_acc + {4'b0, m_a};
         end else begin
            m_acc <= m_acc + {4'b0, m_a};
            m_cnt <= m_cnt - 4'd1;
         end
      end
   end

   typedef struct {int id; int data;} exp_t;
   typedef struct {int id; int a; int b; int exp;} vec_t;

   exp_t sb[$];
   vec_t vecs[7];
   int   checks, failures;
   int   cyc, n_acc, acc_cyc, lat, issues;
   bit   resp_seen;
   logic [3:0] s_req_ready, s_resp_valid;
   logic [7:0] s_resp_data;
   logic       s_busy;

   function automatic void chk(string name, int act, int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endfunction

   function automatic void fail_event(string name);
      checks++;
      failures++;
      $display("FAIL %s actual=no_event required=event", name);
   endfunction

   function automatic void monitor();
      exp_t e;
      cyc++;
      s_req_ready  = req_ready;
      s_resp_valid = resp_valid;
      s_resp_data  = resp_data;
      s_busy       = busy;
      if (rst_n) begin
         if (|(req_valid & req_ready)) begin
            chk("grant_onehot", $countones(req_valid & req_ready), 1);
            n_acc++;
            acc_cyc   = cyc;
            resp_seen = 1'b0;
         end
         if (mul_valid_in && mul_ready_out) issues++;
         if (|resp_valid) begin
            if (!resp_seen) begin
               resp_seen = 1'b1;
               lat       = cyc - acc_cyc;
            end
            chk("resp_onehot", int'(resp_valid), 1 << resp_id);
            if (resp_ready[resp_id]) begin
               if (sb.size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL unexpected_resp actual=id%0d required=none", resp_id);
               end else begin
                  e = sb.pop_front();
                  chk("resp_id", int'(resp_id), e.id);
                  chk("resp_data", int'(resp_data), e.data);
               end
            end
         end
      end
   endfunction

   task automatic tick();
      @(negedge clk);
      monitor();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_acc(input int target, input int bound);
      int t;
      t = 0;
      while (n_acc < target && t < bound) begin
         tick();
         t++;
      end
      if (n_acc < target) fail_event("accept_timeout");
   endtask

   task automatic wait_drain(input int bound);
      int t;
      t = 0;
      while (sb.size() != 0 && t < bound) begin
         tick();
         t++;
      end
      if (sb.size() != 0) begin
         fail_event("resp_timeout");
         sb.delete();
      end
   endtask

   task automatic do_reset();
      rst_n      = 1'b0;
      req_valid  = '0;
      resp_ready = '1;
      tick();
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic run_op(input int id, input int a, input int b, input int exp_data);
      int i0;
      req_a[4*id +: 4] = 4'(a);
      req_b[4*id +: 4] = 4'(b);
      req_valid        = 4'(1 << id);
      sb.push_back('{id, exp_data});
      i0 = issues;
      wait_acc(n_acc + 1, 20);
      req_valid = '0;
      wait_drain(60);
      chk("latency", lat, (a == 0 || b == 0) ? 1 : b + 3);
      chk("issue_count", issues - i0, (a == 0 || b == 0) ? 0 : 1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

   initial begin
      checks = 0; failures = 0; cyc = 0; n_acc = 0; acc_cyc = 0; lat = 0; issues = 0;
      resp_seen = 1'b0;
      rst_n = 1'b0; req_valid = '1; req_a = 16'h1111; req_b = 16'h1111; resp_ready = '1;
      tick();
      tick();
      chk("rst_req_ready", int'(req_ready), 0);
      chk("rst_resp_valid", int'(resp_valid), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_mul_valid_in", int'(mul_valid_in), 0);
      chk("rst_resp_data", int'(resp_data), 0);
      chk("rst_resp_id", int'(resp_id), 0);
      req_valid = '0;
      rst_n     = 1'b1;
      tick();

      vecs[0] = '{0, 3, 5, 15};
      vecs[1] = '{1, 4, 4, 16};
      vecs[2] = '{3, 1, 9, 9};
      vecs[3] = '{2, 7, 0, 0};
      vecs[4] = '{1, 0, 6, 0};
      vecs[5] = '{0, 15, 15, 225};
      vecs[6] = '{2, 2, 3, 6};
      for (int v = 0; v < 7; v++) run_op(vecs[v].id, vecs[v].a, vecs[v].b, vecs[v].exp);

      // All four continuously valid from a fresh pointer.
      do_reset();
      for (int i = 0; i < 4; i++) begin
         req_a[4*i +: 4] = 4'(i + 1);
         req_b[4*i +: 4] = 4'd2;
      end
`ifdef MULT_ARB_FIXED_PRIORITY_EN
      for (int k = 0; k < 5; k++) sb.push_back('{0, 2});
`else
      for (int k = 0; k < 5; k++) sb.push_back('{k % 4, 2 * ((k % 4) + 1)});
`endif
      req_valid = '1;
      wait_acc(n_acc + 5, 120);
      req_valid = '0;
      wait_drain(60);

      // Held response; a requester that withdraws before grant must lose its turn.
      req_a[7:4] = 4'd15; req_b[7:4] = 4'd15;
      req_valid  = 4'b0010;
      resp_ready = 4'b1101;
      sb.push_back('{1, 225});
      wait_acc(n_acc + 1, 20);
      req_a[3:0] = 4'd1;  req_b[3:0] = 4'd1;
      req_a[11:8] = 4'd2; req_b[11:8] = 4'd2;
      req_valid = 4'b0101;
      begin
         int t;
         t = 0;
         while (s_resp_valid == 4'b0 && t < 40) begin
            tick();
            t++;
         end
         if (s_resp_valid == 4'b0) fail_event("hold_resp_timeout");
      end
      for (int k = 0; k < 5; k++) begin
         tick();
         chk("hold_data", int'(s_resp_data), 225);
         chk("hold_valid", int'(s_resp_valid), 2);
         chk("hold_req_ready", int'(s_req_ready), 0);
      end
      req_valid = 4'b0001;
      sb.push_back('{0, 1});
      resp_ready = '1;
      wait_acc(n_acc + 1, 20);
      req_valid = '0;
      wait_drain(60);

      // Reset while the multiplier is mid-operation.
      do_reset();
      req_a[15:12] = 4'd5; req_b[15:12] = 4'd10;
      req_valid = 4'b1000;
      wait_acc(n_acc + 1, 20);
      req_valid = '0;
      begin
         int i0, t;
         i0 = issues;
         t = 0;
         while (issues == i0 && t < 10) begin
            tick();
            t++;
         end
         if (issues == i0) fail_event("issue_timeout");
      end
      tick();
      tick();
      chk("pre_rst_busy", int'(s_busy), 1);
      rst_n = 1'b0;
      req_valid  = 4'b0001;
      req_a[3:0] = 4'd2;
      req_b[3:0] = 4'd3;
      tick();
      chk("midrst_busy", int'(busy), 0);
      chk("midrst_resp_valid", int'(resp_valid), 0);
      chk("midrst_mul_valid_in", int'(mul_valid_in), 0);
      chk("midrst_req_ready", int'(req_ready), 0);
      chk("midrst_resp_data", int'(resp_data), 0);
      chk("midrst_operands", int'({mul_in_a, mul_in_b}), 0);
      tick();
      sb.push_back('{0, 6});
      rst_n = 1'b1;
      wait_acc(n_acc + 1, 20);
      req_valid = '0;
      wait_drain(60);
      chk("post_rst_latency", lat, 6);

      // Requesters 1 and 3 continuously valid.
      do_reset();
      req_a[7:4] = 4'd1;   req_b[7:4] = 4'd1;
      req_a[15:12] = 4'd3; req_b[15:12] = 4'd1;
`ifdef MULT_ARB_FIXED_PRIORITY_EN
      for (int k = 0; k < 4; k++) sb.push_back('{1, 1});
`else
      for (int k = 0; k < 4; k++) sb.push_back((k % 2 == 0) ? '{1, 1} : '{3, 3});
`endif
      req_valid = 4'b1010;
      wait_acc(n_acc + 4, 80);
      req_valid = '0;
      wait_drain(60);

      tick();
      tick();
      chk("scoreboard_empty", sb.size(), 0);
      chk("final_busy", int'(busy), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
